// File: rtl/timer_arb.sv
// Round-robin arbiter that lends one shared down-counter to NREQ timeout requesters.
// Optional macro TIMER_ARB_ABORT_EN adds an abort input that cancels a running timeout.
//
// state | meaning
// IDLE  | counter free; any pending req is arbitrated this cycle
// RUN   | counter owned by owner_q, counting down to zero
module timer_arb #(
    parameter int NREQ = 4,
    parameter int CW   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
`ifdef TIMER_ARB_ABORT_EN
    input  logic                       abort,
`endif
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*CW-1:0]         len,
    output logic [NREQ-1:0]            gnt,
    output logic [NREQ-1:0]            done,
    output logic                       busy,
    output logic [$clog2(NREQ)-1:0]    owner
);

    localparam int OW = $clog2(NREQ);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            busy_q, busy_d;

    logic            found;
    logic [OW-1:0]   win_idx;
    logic [CW-1:0]   win_len;
    logic            abort_req;

`ifdef TIMER_ARB_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Round-robin search starts just past the last owner and wraps.
    always_comb begin
        found   = 1'b0;
        win_idx = owner_q;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(owner_q) + k) % NREQ;
            if (!found && req[OW'(idx)]) begin
                found   = 1'b1;
                win_idx = OW'(idx);
            end
        end
    end

    always_comb begin
        win_len = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (OW'(i) == win_idx) begin
                win_len = len[i*CW +: CW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        gnt_d   = '0;
        done_d  = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d          = RUN;
                    owner_d          = win_idx;
                    // A zero length behaves like one cycle.
                    cnt_d            = (win_len == '0) ? '0 : win_len - CW'(1);
                    gnt_d[win_idx]   = 1'b1;
                end
            end
            RUN: begin
                if (abort_req) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d         = IDLE;
                    done_d[owner_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= OW'(NREQ - 1);
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign owner = owner_q;

endmodule

// File: tb/tb_timer_arb.sv
// Directed self-checking bench for timer_arb (NREQ=4, CW=16).
// Covers the abort path when TIMER_ARB_ABORT_EN is defined.
module tb_timer_arb;

    localparam int NREQ = 4;
    localparam int CW   = 16;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*CW-1:0]  len;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     done;
    logic                busy;
    logic [1:0]          owner;
`ifdef TIMER_ARB_ABORT_EN
    logic                abort;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    timer_arb #(.NREQ(NREQ), .CW(CW)) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef TIMER_ARB_ABORT_EN
        .abort (abort),
`endif
        .req   (req),
        .len   (len),
        .gnt   (gnt),
        .done  (done),
        .busy  (busy),
        .owner (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the edge that produced them.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int i, input logic [CW-1:0] v);
        len[i*CW +: CW] = v;
    endtask

    initial begin
        rst = 1'b0;
        req = '0;
        len = '0;
`ifdef TIMER_ARB_ABORT_EN
        abort = 1'b0;
`endif
        step();
        step();
        check("rst_gnt",   32'(gnt),   32'h0);
        check("rst_done",  32'(done),  32'h0);
        check("rst_busy",  32'(busy),  32'h0);
        check("rst_owner", 32'(owner), 32'h3);

        // Single timeout: req[2], len 5 in cycle 0.
        rst = 1'b1;
        req = 4'b0100;
        set_len(2, 16'd5);
        step();
        check("single_gnt",  32'(gnt),  32'h4);
        check("single_busy", 32'(busy), 32'h1);
        req = '0;
        for (int c = 2; c <= 5; c++) begin
            step();
            check("single_run_busy", 32'(busy), 32'h1);
            check("single_run_done", 32'(done), 32'h0);
        end
        step();
        check("single_done",       32'(done),  32'h4);
        check("single_done_busy",  32'(busy),  32'h0);
        check("single_done_gnt",   32'(gnt),   32'h0);
        check("single_owner",      32'(owner), 32'h2);

        // Round robin from reset, all requesters held, len 3.
        rst = 1'b0;
        step();
        rst = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_len(i, 16'd3);
        step();
        for (int g = 0; g < 5; g++) begin
            check("rr_gnt", 32'(gnt), 32'(1) << (g % 4));
            if (g == 4) req = '0;
            step();
            step();
            step();
            check("rr_done", 32'(done), 32'(1) << (g % 4));
            if (g < 4) step();
        end

        // Zero length behaves exactly like length 1.
        req = 4'b0001;
        set_len(0, 16'd0);
        step();
        check("zero_gnt",  32'(gnt),  32'h1);
        check("zero_busy", 32'(busy), 32'h1);
        req = '0;
        step();
        check("zero_done", 32'(done), 32'h1);
        check("zero_idle", 32'(busy), 32'h0);
        req = 4'b0001;
        set_len(0, 16'd1);
        step();
        check("one_gnt", 32'(gnt), 32'h1);
        req = '0;
        step();
        check("one_done", 32'(done), 32'h1);

        // len change after grant, and a one-cycle req[3] pulse during RUN.
        req = 4'b0010;
        set_len(1, 16'd10);
        step();
        check("lenchg_gnt", 32'(gnt), 32'h2);
        req = '0;
        set_len(1, 16'd2);
        step();
        req = 4'b1000;
        step();
        req = '0;
        for (int c = 3; c <= 9; c++) step();
        check("lenchg_not_early", 32'(done), 32'h0);
        check("lenchg_busy9",     32'(busy), 32'h1);
        step();
        check("lenchg_done", 32'(done), 32'h2);
        step();
        check("drop_no_gnt",  32'(gnt),  32'h0);
        check("drop_no_busy", 32'(busy), 32'h0);

        // Reset three cycles into a len 8 timeout of requester 1.
        req = 4'b0010;
        set_len(1, 16'd8);
        step();
        check("rstrun_gnt", 32'(gnt), 32'h2);
        req = '0;
        step();
        step();
        step();
        rst = 1'b0;
        step();
        check("rstrun_done",  32'(done),  32'h0);
        check("rstrun_busy",  32'(busy),  32'h0);
        check("rstrun_owner", 32'(owner), 32'h3);
        rst = 1'b1;
        req = 4'b0011;
        step();
        check("rstrun_next_gnt", 32'(gnt), 32'h1);
        req = '0;
        step();
        check("rstrun_next_done", 32'(done), 32'h1);
        step();
        check("rstrun_no_stale_done", 32'(done), 32'h0);

`ifdef TIMER_ARB_ABORT_EN
        // Abort lands in the counter==0 cycle; a pending req follows.
        req = 4'b0100;
        set_len(2, 16'd3);
        step();
        check("abort_gnt", 32'(gnt), 32'h4);
        req = '0;
        step();
        step();
        abort = 1'b1;
        req   = 4'b0001;
        step();
        check("abort_no_done", 32'(done), 32'h0);
        check("abort_busy",    32'(busy), 32'h0);
        abort = 1'b0;
        step();
        check("abort_next_gnt", 32'(gnt), 32'h1);
        req = '0;
        step();
        check("abort_next_done", 32'(done), 32'h1);
        abort = 1'b1;
        req   = 4'b0010;
        set_len(1, 16'd2);
        step();
        check("abort_idle_ignored", 32'(gnt), 32'h2);
        abort = 1'b0;
        req   = '0;
        step();
        step();
        check("abort_idle_done", 32'(done), 32'h2);
`endif

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_arb.md
TIMER_ARB -- requirements
Module: timer_arb

Interface
REQ-001 The block SHALL have parameter NREQ, default 4: number of requesters sharing the single down-counter; legal range 2..8.
REQ-002 The block SHALL have parameter CW, default 16: width of each requester's timeout length.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port req, input, NREQ bits: per-requester timeout request, held high until granted.
REQ-006 The block SHALL have port len, input, NREQ*CW bits: timeout length of requester i in bits [i*CW +: CW], in clk cycles.
REQ-007 The block SHALL have port gnt, output reg, NREQ bits: one-cycle one-hot pulse, high when requester i's timeout is accepted.
REQ-008 The block SHALL have port done, output reg, NREQ bits: one-cycle one-hot pulse, high when requester i's timeout expires.
REQ-009 The block SHALL have port busy, output reg, 1 bit: counter owned (state RUN).
REQ-010 The block SHALL have port owner, output reg, clog2(NREQ) bits: index of the current or most recent owner.

Function
REQ-011 The block SHALL use two states: IDLE and RUN.
REQ-012 In IDLE with any req bit high, the block SHALL pick a winner by round-robin, searching from (owner+1) mod NREQ upward with wrap-around.
REQ-013 On the clock edge that ends the arbitration cycle, the block SHALL:
- enter RUN
- set owner to the winner
- load the counter with max(len[winner],1)-1
- assert gnt[winner] for exactly one cycle, which is the first RUN cycle.
REQ-014 The block SHALL sample len only in the arbitration cycle; later changes to len SHALL NOT affect a running timeout.
REQ-015 In RUN with the counter nonzero, the block SHALL decrement the counter by 1 each cycle.
REQ-016 In RUN with the counter at zero, the block SHALL go to IDLE on the next edge and pulse done[owner] high for the one cycle spent in IDLE.
REQ-017 Timing: with gnt high in cycle G, done SHALL be high in cycle G+max(len,1); busy SHALL be high in cycles G through G+max(len,1)-1.
REQ-018 The cycle in which done is high SHALL also be an arbitration cycle, so a pending req gets gnt in the next cycle; the minimum request-to-request gap is one cycle.
REQ-019 A req dropped before its gnt SHALL be discarded with no side effects.
REQ-020 req bits that are high while in RUN SHALL be ignored until IDLE.
REQ-021 The block SHALL never raise more than one gnt bit in a cycle, and never more than one done bit in a cycle.
REQ-022 gnt and done SHALL never be high in the same cycle.
REQ-023 The block SHALL ignore req[owner] while gnt[owner] is high; a requester that keeps req high re-requests.

Reset
REQ-024 While rst is low at a clock edge, the block SHALL set: state IDLE, counter 0, gnt 0, done 0, busy 0, owner NREQ-1, so that requester 0 has first priority.
REQ-025 Reset asserted during RUN SHALL abandon the timeout with no done pulse.
REQ-026 The first arbitration after reset SHALL be in the cycle after rst returns high.

Configuration
REQ-027 The block SHALL support the macro TIMER_ARB_ABORT_EN.
- When defined: the block adds input abort (1 bit).
- abort high in a RUN cycle SHALL force IDLE on the next edge with no done pulse, and that IDLE cycle SHALL be a normal arbitration cycle.
- abort in IDLE SHALL be ignored.
- If abort and counter==0 occur in the same cycle, abort SHALL win and no done is raised.
- When not defined: there is no abort port, and every granted timeout runs to done.

Verification
REQ-028 The bench SHALL cover a single timeout:
- Stimulus: NREQ=4, CW=16; req[2]=1 with len=5 in cycle 0.
- Response: gnt[2] in cycle 1; done[2] in cycle 6; busy high in cycles 1 through 5; owner=2.
REQ-029 The bench SHALL cover round-robin fairness:
- Stimulus: req=4'b1111 held continuously, all len=3, starting after reset.
- Response: grant order 0,1,2,3,0; grants 4 cycles apart.
REQ-030 The bench SHALL cover zero length:
- Stimulus: req[0] with len=0.
- Response: gnt[0] in cycle G and done[0] in cycle G+1, identical to len=1.
REQ-031 The bench SHALL cover a len change mid-run and a dropped request:
- Stimulus: change len[1] from 10 to 2 after gnt[1]; separately, pulse req[3] for one cycle during RUN.
- Response: done[1] arrives 10 cycles after gnt[1]; req[3] is never granted.
REQ-032 The bench SHALL cover reset mid-run:
- Stimulus: rst low for 1 cycle, 3 cycles into a len=8 timeout of requester 1.
- Response: no done; busy=0; owner=3; the next grant with req=4'b0011 goes to 0.
REQ-033 The bench SHALL cover abort, with TIMER_ARB_ABORT_EN defined:
- Stimulus: abort high in the cycle where counter==0.
- Response: no done; busy=0 in the next cycle; a pending req is granted one cycle later.
